// File: rtl/cpu_disp_pkg.sv
// Shared constants and types for the CPU single-step and 7-segment display block.
package cpu_disp_pkg;

  // ViewSel encodings: upper byte | lower byte of the displayed 16-bit word
  localparam logic [1:0] VIEW_PC  = 2'b00;  // PC[7:0]      | PCNext[7:0]
  localparam logic [1:0] VIEW_RS  = 2'b01;  // rs address   | ReadData1[7:0]
  localparam logic [1:0] VIEW_RT  = 2'b10;  // rt address   | ReadData2[7:0]
  localparam logic [1:0] VIEW_ALU = 2'b11;  // ALU result   | write-back data

  // Control-unit state that marks instruction fetch
  localparam logic [2:0] CPU_STATE_FETCH = 3'b000;

  // Digit whose decimal point separates the two byte fields
  localparam logic [1:0] SEP_DIGIT = 2'd2;

  // All segments and the decimal point off (active low)
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex digit -> {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  // Values captured at each digit-slot boundary and held for the whole slot
  typedef struct packed {
    logic [1:0]  view;
    logic [15:0] word;
    logic        fetch;
  } disp_hold_t;

  // Full active-low segment byte {dp,g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp_lit);
    return {~dp_lit, HEX_SEG[nibble]};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw, bouncy push-button and debounces it into a clean level.
module button_debounce
  import cpu_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic BtnIn,
  output logic BtnOut
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          db_q,   db_d;

  // Next-state for synchronizer, stability counter and debounced level
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sync_d = {sync_q[0], BtnIn};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      db_d  = ~db_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; the first sync stage may go metastable, the second absorbs it
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign BtnOut = db_q;

endmodule

// File: rtl/cpu_step_display.sv
// Board companion for the multi-cycle CPU: debounced single-step clock, step
// counter, and a time-multiplexed 4-digit common-anode 7-segment view.
module cpu_step_display
  import cpu_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        StepBtn,
  input  logic [1:0]  ViewSel,
  input  logic [31:0] PC,
  input  logic [31:0] PCNext,
  input  logic [4:0]  RsAddr,
  input  logic [31:0] RsData,
  input  logic [4:0]  RtAddr,
  input  logic [31:0] RtData,
  input  logic [31:0] ALURes,
  input  logic [31:0] WrData,
  input  logic [2:0]  CpuState,
  output logic        CpuStepClk,
  output logic [15:0] StepCount,
  output logic [3:0]  An,
  output logic [7:0]  Seg
);

  localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  logic           db_level;
  logic           db_prev_q,    db_prev_d;
  logic [15:0]    step_count_q, step_count_d;
  logic [SCW-1:0] scan_cnt_q,   scan_cnt_d;
  logic [1:0]     digit_q,      digit_d;
  logic [3:0]     an_q,         an_d;
  logic [7:0]     seg_q,        seg_d;
  disp_hold_t     hold_q,       hold_d;
  logic [15:0]    live_word;
  logic           scan_tc;

  // Only the low byte of each wide CPU bus is shown
  logic unused_hi_bytes;
  assign unused_hi_bytes = ^{PC[31:8], PCNext[31:8], RsData[31:8],
                             RtData[31:8], ALURes[31:8], WrData[31:8]};

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK    (CLK),
    .Reset  (Reset),
    .BtnIn  (StepBtn),
    .BtnOut (db_level)
  );

  // Step counter: count debounced rising edges, wrapping at 16 bits
  always_comb begin
    db_prev_d    = db_level;
    step_count_d = step_count_q;
    if (db_level && !db_prev_q) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  // Live view mux; only sampled at slot boundaries
  always_comb begin
    live_word = {PC[7:0], PCNext[7:0]};
    case (ViewSel)
      VIEW_PC:  live_word = {PC[7:0], PCNext[7:0]};
      VIEW_RS:  live_word = {3'b000, RsAddr, RsData[7:0]};
      VIEW_RT:  live_word = {3'b000, RtAddr, RtData[7:0]};
      VIEW_ALU: live_word = {ALURes[7:0], WrData[7:0]};
      default:  live_word = {PC[7:0], PCNext[7:0]};
    endcase
  end

  // Scan divider and digit advance; outputs and hold register change only at terminal count
  always_comb begin
    scan_tc    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    hold_d     = hold_q;
    an_d       = an_q;
    seg_d      = seg_q;
    if (scan_tc) begin
      digit_d      = digit_q + 2'd1;
      hold_d.view  = ViewSel;
      hold_d.word  = live_word;
      hold_d.fetch = (CpuState == CPU_STATE_FETCH);
      an_d         = ~(4'b0001 << digit_d);
      seg_d        = seg_encode(hold_d.word[{digit_d, 2'b00} +: 4],
                                (digit_d == SEP_DIGIT) ||
                                ((digit_d == 2'd0) && hold_d.fetch));
    end
  end

  // State registers; display stays blank from reset until the first slot boundary
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      db_prev_q    <= 1'b0;
      step_count_q <= '0;
      scan_cnt_q   <= '0;
      digit_q      <= '0;
      hold_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      db_prev_q    <= db_prev_d;
      step_count_q <= step_count_d;
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
      hold_q       <= hold_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign CpuStepClk = db_level;
  assign StepCount  = step_count_q;
  assign An         = an_q;
  assign Seg        = seg_q;

endmodule

// File: tb/tb_cpu_step_display.sv
// Scoreboard bench for cpu_step_display: stimulus pushes expected step edges and
// display slots into queues, independent monitors pop and compare.
module tb_cpu_step_display;

  localparam int DEB       = 4;
  localparam int SCAN      = 3;
  localparam int PRESS_LAT = 2 + DEB;

  logic        CLK      = 1'b0;
  logic        Reset    = 1'b1;
  logic        StepBtn  = 1'b0;
  logic [1:0]  ViewSel  = 2'b00;
  logic [31:0] PC       = '0;
  logic [31:0] PCNext   = '0;
  logic [4:0]  RsAddr   = '0;
  logic [31:0] RsData   = '0;
  logic [4:0]  RtAddr   = '0;
  logic [31:0] RtData   = '0;
  logic [31:0] ALURes   = '0;
  logic [31:0] WrData   = '0;
  logic [2:0]  CpuState = 3'b001;
  logic        CpuStepClk;
  logic [15:0] StepCount;
  logic [3:0]  An;
  logic [7:0]  Seg;

  cpu_step_display #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_DIV       (SCAN)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .StepBtn    (StepBtn),
    .ViewSel    (ViewSel),
    .PC         (PC),
    .PCNext     (PCNext),
    .RsAddr     (RsAddr),
    .RsData     (RsData),
    .RtAddr     (RtAddr),
    .RtData     (RtData),
    .ALURes     (ALURes),
    .WrData     (WrData),
    .CpuState   (CpuState),
    .CpuStepClk (CpuStepClk),
    .StepCount  (StepCount),
    .An         (An),
    .Seg        (Seg)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Hand-derived active-low {dp,g,f,e,d,c,b,a} for 0..F with dp off
  localparam logic [7:0] HEX8 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] exp_seg(input logic [15:0] word, input int d, input logic [2:0] st);
    logic [7:0] s;
    s = HEX8[word[d*4 +: 4]];
    if (d == 2 || (d == 0 && st == 3'b000)) s[7] = 1'b0;
    return s;
  endfunction

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    string      tag;
  } disp_exp_t;

  typedef struct {
    int unsigned rise_cyc;
    logic [15:0] count;
  } step_exp_t;

  disp_exp_t disp_q[$];
  step_exp_t step_q[$];

  // ---------------- display monitor ----------------
  int          slot_cnt = 0;
  int unsigned last_chg = 0;
  logic [3:0]  prev_an  = 4'hF;

  always @(negedge CLK) begin
    disp_exp_t  e;
    logic [3:0] an_e;
    if (Reset) begin
      slot_cnt = 0;
      prev_an  = 4'hF;
      last_chg = cyc;
    end else if (An !== prev_an) begin
      check("slot_len", cyc - last_chg, SCAN);
      an_e = ~(4'b0001 << ((slot_cnt + 1) % 4));
      check("an_seq", {28'b0, An}, {28'b0, an_e});
      if (disp_q.size() > 0) begin
        e = disp_q.pop_front();
        check({e.tag, "_an"}, {28'b0, An}, {28'b0, e.an});
        check({e.tag, "_seg"}, {24'b0, Seg}, {24'b0, e.seg});
      end
      slot_cnt++;
      last_chg = cyc;
      prev_an  = An;
    end
  end

  // ---------------- step monitor ----------------
  logic        prev_clk    = 1'b0;
  logic        pend_valid  = 1'b0;
  logic [15:0] pend_count  = '0;

  always @(negedge CLK) begin
    step_exp_t se;
    if (Reset) begin
      prev_clk   = 1'b0;
      pend_valid = 1'b0;
    end else begin
      if (CpuStepClk && !prev_clk) begin
        if (step_q.size() == 0) begin
          check("unexpected_rise", {31'b0, CpuStepClk}, 32'd0);
        end else begin
          se = step_q.pop_front();
          check("rise_cycle", cyc, se.rise_cyc);
          pend_count = se.count;
          pend_valid = 1'b1;
        end
      end else if (pend_valid) begin
        check("step_count", {16'b0, StepCount}, {16'b0, pend_count});
        pend_valid = 1'b0;
      end
      prev_clk = CpuStepClk;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] model_count = '0;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic press();
    step_exp_t e;
    model_count = model_count + 16'd1;
    e.rise_cyc  = cyc + PRESS_LAT;
    e.count     = model_count;
    step_q.push_back(e);
    StepBtn = 1'b1;
  endtask

  task automatic wait_slot();
    int s;
    s = slot_cnt;
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge CLK);
      #1;
      if (slot_cnt != s) return;
    end
    check("slot_timeout", slot_cnt, s + 1);
  endtask

  task automatic drain_disp();
    for (int i = 0; i < 20 * SCAN && disp_q.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    check("disp_drain", disp_q.size(), 0);
  endtask

  task automatic push_slots(input logic [15:0] word, input logic [2:0] st, input string tag);
    disp_exp_t e;
    int d;
    for (int k = 1; k <= 4; k++) begin
      d     = (slot_cnt + k) % 4;
      e.an  = ~(4'b0001 << d);
      e.seg = exp_seg(word, d, st);
      e.tag = tag;
      disp_q.push_back(e);
    end
  endtask

  task automatic run_view(input logic [1:0] view, input logic [15:0] word,
                          input logic [2:0] st, input string tag);
    wait_slot();
    ViewSel  = view;
    CpuState = st;
    push_slots(word, st, tag);
    drain_disp();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] cur_an;
    logic [7:0] cur_seg;
    int         d;
    logic       bounce [5];
    bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    wait_cycles(3);
    check("rst_an",    {28'b0, An},         32'hF);
    check("rst_seg",   {24'b0, Seg},        32'hFF);
    check("rst_clk",   {31'b0, CpuStepClk}, 32'd0);
    check("rst_count", {16'b0, StepCount},  32'd0);

    @(negedge CLK);
    #1 Reset = 1'b0;
    wait_cycles(2);
    check("blank_an",  {28'b0, An},  32'hF);
    check("blank_seg", {24'b0, Seg}, 32'hFF);

    // Bounce shorter than the debounce window
    foreach (bounce[i]) begin
      StepBtn = bounce[i];
      wait_cycles(1);
    end
    StepBtn = 1'b0;
    wait_cycles(15);
    check("bounce_clk",   {31'b0, CpuStepClk}, 32'd0);
    check("bounce_count", {16'b0, StepCount},  32'd0);

    // Held press: one rise PRESS_LAT cycles later, one fall after release
    press();
    wait_cycles(20);
    check("press_drain", step_q.size(), 0);
    StepBtn = 1'b0;
    wait_cycles(PRESS_LAT - 1);
    check("fall_not_yet", {31'b0, CpuStepClk}, 32'd1);
    wait_cycles(1);
    check("fall_done", {31'b0, CpuStepClk}, 32'd0);
    wait_cycles(10);
    check("one_step", {16'b0, StepCount}, 32'd1);

    // Display views
    PC     = 32'h0000_0014;
    PCNext = 32'h0000_0018;
    run_view(2'b00, 16'h1418, 3'b001, "view_pc");
    RsAddr = 5'h13;
    RsData = 32'hFFFF_FF5A;
    run_view(2'b01, 16'h135A, 3'b010, "view_rs");
    RtAddr = 5'h1F;
    RtData = 32'h0000_0007;
    run_view(2'b10, 16'h1F07, 3'b000, "view_rt_fetch");

    // View change mid-slot takes effect only at the next boundary
    ViewSel  = 2'b00;
    CpuState = 3'b001;
    wait_slot();
    wait_slot();
    d       = slot_cnt % 4;
    cur_an  = ~(4'b0001 << d);
    cur_seg = exp_seg(16'h1418, d, 3'b001);
    wait_cycles(1);
    ViewSel  = 2'b11;
    ALURes   = 32'h0000_00AB;
    WrData   = 32'h0000_00CD;
    CpuState = 3'b000;
    wait_cycles(1);
    check("midslot_an",  {28'b0, An},  {28'b0, cur_an});
    check("midslot_seg", {24'b0, Seg}, {24'b0, cur_seg});
    push_slots(16'hABCD, 3'b000, "view_alu");
    drain_disp();

    // Step counter wrap: preload to FFFE, then two real steps
    @(negedge CLK);
    dut.step_count_q = 16'hFFFE;
    model_count      = 16'hFFFE;
    #1;
    for (int i = 0; i < 2; i++) begin
      press();
      wait_cycles(10);
      StepBtn = 1'b0;
      wait_cycles(10);
    end
    check("wrap_drain", step_q.size(), 0);
    check("wrap_count", {16'b0, StepCount}, 32'd0);

    // Reset mid-scan with button held, then held through reset release
    press();
    wait_cycles(10);
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_clk",   {31'b0, CpuStepClk}, 32'd0);
    check("async_rst_count", {16'b0, StepCount},  32'd0);
    check("async_rst_an",    {28'b0, An},         32'hF);
    check("async_rst_seg",   {24'b0, Seg},        32'hFF);
    check("async_rst_drain", step_q.size(), 0);
    model_count = '0;
    wait_cycles(3);
    @(negedge CLK);
    #1 Reset = 1'b0;
    press();
    wait_cycles(12);
    check("held_rst_drain", step_q.size(), 0);
    StepBtn = 1'b0;
    wait_cycles(10);
    check("held_rst_count", {16'b0, StepCount}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
